// File: rtl/bp_clint_responder.sv
// bp_clint_responder
//   CLINT target on the uncached I/O request path. It accepts one
//   single-beat read or write at a time and returns exactly one response
//   per request. It owns the mtime, mtimecmp and msip registers and drives
//   the machine timer and software interrupt lines.
//
// Ports
//   clk_i, reset_n_i        clock and asynchronous active-low reset
//   req_*                   request channel (valid/ready handshake)
//   resp_*                  response channel (valid/yumi handshake)
//   rtc_tick_i              one-cycle pulse that advances mtime by one
//   timer_irq_o             registered (mtime >= mtimecmp)
//   software_irq_o          msip bit 0
//
// Register map (offset = addr - clint_base_p, low 16 bits decoded)
//   0x0000 msip, 0x4000 mtimecmp, 0xBFF8 mtime.
//   For 4B accesses, offset bit 2 selects the upper word.
//
// Build option
//   BP_CLINT_ERR_RESP_EN : when defined, unmapped offsets respond with
//   resp_err_o = 1. When undefined, resp_err_o is tied to 0.
module bp_clint_responder #(
    parameter int                     paddr_width_p = 40,
    parameter int                     dword_width_p = 64,
    parameter logic [paddr_width_p-1:0] clint_base_p = 40'h0030_0000
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     req_v_i,
    output logic                     req_ready_and_o,
    input  logic                     req_we_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [1:0]               req_size_i,
    input  logic [dword_width_p-1:0] req_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_yumi_i,
    output logic [dword_width_p-1:0] resp_data_o,
    output logic                     resp_err_o,
    input  logic                     rtc_tick_i,
    output logic                     timer_irq_o,
    output logic                     software_irq_o
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

    state_e                     state_q, state_d;
    logic [dword_width_p-1:0]   mtime_q, mtime_d;
    logic [dword_width_p-1:0]   mtimecmp_q, mtimecmp_d;
    logic                       msip_q, msip_d;
    logic [dword_width_p-1:0]   resp_data_q, resp_data_d;
    logic                       resp_err_q, resp_err_d;
    logic                       timer_irq_q, timer_irq_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [paddr_width_p-1:0] off;
    logic [15:0]              off16;
    logic                     is_8b, hi_word;
    logic                     hit_msip, hit_cmp, hit_time, hit_any;
    logic                     unused_off_hi;

    assign off           = req_addr_i - clint_base_p;
    assign off16         = off[15:0];
    // Only the low 16 offset bits take part in the decode.
    assign unused_off_hi = ^off[paddr_width_p-1:16];

    assign is_8b   = (req_size_i == 2'b11);
    assign hi_word = off16[2];

    // An 8B access must be 8B aligned. A 4B access may address either half.
    assign hit_msip = (off16 == 16'h0000);
    assign hit_cmp  = (off16[15:3] == 13'h0800) && (off16[1:0] == 2'b00)
                      && !(is_8b && hi_word);
    assign hit_time = (off16[15:3] == 13'h17FF) && (off16[1:0] == 2'b00)
                      && !(is_8b && hi_word);
    assign hit_any  = hit_msip | hit_cmp | hit_time;

    // Read mux. A 4B read returns the selected half, zero-extended.
    logic [dword_width_p-1:0] rd_sel, rd_data;
    always_comb begin
        rd_sel = '0;
        if (hit_msip)      rd_sel = {{(dword_width_p-1){1'b0}}, msip_q};
        else if (hit_cmp)  rd_sel = mtimecmp_q;
        else if (hit_time) rd_sel = mtime_q;

        if (is_8b)        rd_data = rd_sel;
        else if (hi_word) rd_data = {32'h0, rd_sel[63:32]};
        else              rd_data = {32'h0, rd_sel[31:0]};
    end

    // Write merge. A 4B write replaces one half and keeps the other half.
    function automatic logic [63:0] merge(input logic [63:0] old_v,
                                          input logic [63:0] wd,
                                          input logic        b8,
                                          input logic        hi);
        if (b8)      return wd;
        else if (hi) return {wd[31:0], old_v[31:0]};
        else         return {old_v[63:32], wd[31:0]};
    endfunction

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        // The tick is the default update. A write in the same cycle
        // overrides it, so that tick is dropped.
        mtime_d     = rtc_tick_i ? mtime_q + 1'b1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        // Compare on current register values. The interrupt therefore lags
        // a tick or a write by one cycle.
        timer_irq_d = (mtime_q >= mtimecmp_q);

        case (state_q)
            IDLE: begin
                if (req_v_i) begin
                    state_d     = RESP;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    if (req_we_i) begin
                        if (hit_msip) msip_d = req_data_i[0];
                        if (hit_cmp)
                            mtimecmp_d = merge(mtimecmp_q, req_data_i, is_8b, hi_word);
                        if (hit_time)
                            mtime_d = merge(mtime_q, req_data_i, is_8b, hi_word);
                    end else begin
                        resp_data_d = rd_data;
                    end
`ifdef BP_CLINT_ERR_RESP_EN
                    resp_err_d = !hit_any;
`endif
                end
            end
            RESP: begin
                if (resp_yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef BP_CLINT_ERR_RESP_EN
    logic unused_hit_any;
    assign unused_hit_any = hit_any;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    // Ready is held low for as long as reset is applied.
    assign req_ready_and_o = (state_q == IDLE) && reset_n_i;
    assign resp_v_o        = (state_q == RESP);
    assign resp_data_o     = resp_data_q;
    assign resp_err_o      = resp_err_q;
    assign timer_irq_o     = timer_irq_q;
    assign software_irq_o  = msip_q;

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed bench for bp_clint_responder. Inputs change 1ns after the rising
// edge, and outputs are sampled at that same point.
module tb_bp_clint_responder;

    localparam logic [39:0] BASE = 40'h0030_0000;
    localparam logic [1:0]  SZ4  = 2'b10;
    localparam logic [1:0]  SZ8  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_v = 1'b0, req_ready, req_we = 1'b0;
    logic [39:0] req_addr = '0;
    logic [1:0]  req_size = 2'b11;
    logic [63:0] req_data = '0;
    logic        resp_v, resp_yumi = 1'b0, resp_err;
    logic [63:0] resp_data;
    logic        rtc_tick = 1'b0, timer_irq, software_irq;

    int vectors = 0;
    int miscompares = 0;

`ifdef BP_CLINT_ERR_RESP_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    bp_clint_responder dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .req_v_i        (req_v),
        .req_ready_and_o(req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_size_i     (req_size),
        .req_data_i     (req_data),
        .resp_v_o       (resp_v),
        .resp_yumi_i    (resp_yumi),
        .resp_data_o    (resp_data),
        .resp_err_o     (resp_err),
        .rtc_tick_i     (rtc_tick),
        .timer_irq_o    (timer_irq),
        .software_irq_o (software_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Issues one request, optionally with a tick in the same cycle, and
    // checks that the response becomes valid one cycle later.
    task automatic issue(input logic we, input logic [15:0] off, input logic [1:0] sz,
                         input logic [63:0] wd, input logic tick);
        chk("ready_before_req", {63'h0, req_ready}, 64'd1);
        req_v = 1'b1; req_we = we; req_addr = BASE + {24'h0, off};
        req_size = sz; req_data = wd; rtc_tick = tick;
        step();
        req_v = 1'b0; rtc_tick = 1'b0;
        chk("resp_latency", {63'h0, resp_v}, 64'd1);
        chk("ready_in_resp", {63'h0, req_ready}, 64'd0);
    endtask

    task automatic consume();
        resp_yumi = 1'b1;
        step();
        resp_yumi = 1'b0;
        chk("resp_v_after_yumi", {63'h0, resp_v}, 64'd0);
    endtask

    task automatic wr(input logic [15:0] off, input logic [1:0] sz, input logic [63:0] wd);
        issue(1'b1, off, sz, wd, 1'b0);
        chk("write_resp_data", resp_data, 64'd0);
        consume();
    endtask

    task automatic rd(input string tag, input logic [15:0] off, input logic [1:0] sz,
                      input logic [63:0] exp);
        issue(1'b0, off, sz, 64'h0, 1'b0);
        chk(tag, resp_data, exp);
        consume();
    endtask

    initial begin
        // Check the state while reset is applied.
        #12;
        chk("rst_ready",  {63'h0, req_ready}, 64'd0);
        chk("rst_resp_v", {63'h0, resp_v}, 64'd0);
        chk("rst_data",   resp_data, 64'd0);
        chk("rst_err",    {63'h0, resp_err}, 64'd0);
        chk("rst_tirq",   {63'h0, timer_irq}, 64'd0);
        chk("rst_sirq",   {63'h0, software_irq}, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        step();

        // mtimecmp reads all-ones after reset.
        rd("mtimecmp_rst", 16'h4000, SZ8, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("tirq_after_rst", {63'h0, timer_irq}, 64'd0);

        // Set mtimecmp = 5 and apply five ticks. The interrupt rises one
        // cycle after the fifth tick.
        wr(16'h4000, SZ8, 64'd5);
        rtc_tick = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rtc_tick = 1'b0;
        chk("tirq_at_5th_tick", {63'h0, timer_irq}, 64'd0);
        step();
        chk("tirq_one_later", {63'h0, timer_irq}, 64'd1);
        rd("mtime_eq5", 16'hBFF8, SZ8, 64'd5);

        // mtime wraps from all-ones to zero.
        wr(16'hBFF8, SZ8, 64'hFFFF_FFFF_FFFF_FFFF);
        rtc_tick = 1'b1; step(); rtc_tick = 1'b0;
        rd("mtime_wrap", 16'hBFF8, SZ8, 64'd0);

        // A write to mtime wins over a tick in the same cycle.
        issue(1'b1, 16'hBFF8, SZ8, 64'h10, 1'b1);
        consume();
        rd("mtime_write_wins", 16'hBFF8, SZ8, 64'h10);
        rd("mtime_lo_4b", 16'hBFF8, SZ4, 64'h10);

        // A 4B write to the upper half keeps the lower half.
        wr(16'h4000, SZ8, 64'h0);
        wr(16'h4004, SZ4, 64'hDEAD_BEEF_0000_1234);
        rd("mtimecmp_merge", 16'h4000, SZ8, 64'h0000_1234_0000_0000);
        rd("mtimecmp_hi_4b", 16'h4004, SZ4, 64'h0000_1234);
        chk("tirq_cmp_low", {63'h0, timer_irq}, 64'd0);

        // Only msip bit 0 is stored.
        wr(16'h0000, SZ4, 64'hFFFF_FFFF);
        chk("sirq_set", {63'h0, software_irq}, 64'd1);
        rd("msip_readback", 16'h0000, SZ4, 64'd1);

        // The response holds while yumi stays low.
        issue(1'b0, 16'h0000, SZ4, 64'h0, 1'b0);
        rtc_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_v",     {63'h0, resp_v}, 64'd1);
            chk("hold_data",  resp_data, 64'd1);
            chk("hold_ready", {63'h0, req_ready}, 64'd0);
        end
        rtc_tick = 1'b0;
        consume();
        // The read of mtime is a snapshot. The 10 ticks above advance mtime.
        rd("mtime_after_hold", 16'hBFF8, SZ8, 64'h1A);

        // An unmapped offset returns zero data and completes normally.
        issue(1'b0, 16'h2000, SZ8, 64'h0, 1'b0);
        chk("unmapped_data", resp_data, 64'd0);
        chk("unmapped_err",  {63'h0, resp_err}, {63'h0, EXP_ERR});
        consume();
        issue(1'b1, 16'h2000, SZ8, 64'hFFFF, 1'b0);
        chk("unmapped_wr_err", {63'h0, resp_err}, {63'h0, EXP_ERR});
        consume();

        // Reset in RESP drops the pending response immediately.
        issue(1'b0, 16'h4000, SZ8, 64'h0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_resp_v",  {63'h0, resp_v}, 64'd0);
        chk("rst_mid_ready",   {63'h0, req_ready}, 64'd0);
        chk("rst_mid_sirq",    {63'h0, software_irq}, 64'd0);
        @(negedge clk); reset_n = 1'b1;
        step();
        chk("post_rst_ready",  {63'h0, req_ready}, 64'd1);
        chk("post_rst_resp_v", {63'h0, resp_v}, 64'd0);
        rd("post_rst_cmp", 16'h4000, SZ8, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("post_rst_mtime", 16'hBFF8, SZ8, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog that stops a run which fails to reach the end.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bp_clint_responder.md
Name: bp_clint_responder

Overview:
- Memory-mapped CLINT responder at the target end of the core's uncached I/O request path.
- Accepts single-beat read/write requests from the core's I/O initiator and returns one response per request.
- Owns the machine timer (mtime), timer compare (mtimecmp) and software-interrupt (msip) registers.
- Drives the machine timer and software interrupt lines into the core's interrupt logic.

Parameters:
- paddr_width_p, 40, physical address width of request addr.
- dword_width_p, 64, data width; fixed at 64, other values unsupported.
- clint_base_p, 40'h0030_0000, base address; offset = addr - clint_base_p, low 16 bits decoded.

Ports:
- clk_i  in  1  single clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  1  request valid.
- req_ready_and_o  out  1  request accepted when req_v_i & req_ready_and_o.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  paddr_width_p  byte address.
- req_size_i  in  2  2'b10 = 4B, 2'b11 = 8B; 2'b00/2'b01 handled as 4B.
- req_data_i  in  64  write data; 4B writes use bits [31:0].
- resp_v_o  out  1  response valid.
- resp_yumi_i  in  1  response consumed; legal only while resp_v_o = 1.
- resp_data_o  out  64  read data (zero for writes); 4B reads zero-extended.
- resp_err_o  out  1  unmapped access (see Optional Feature).
- rtc_tick_i  in  1  single-cycle pulse; mtime += 1 per pulse.
- timer_irq_o  out  1  machine timer interrupt.
- software_irq_o  out  1  machine software interrupt.

Behaviour:
- Register map (offset):
  - 0x0000 msip: bit 0 only; other bits read 0 and ignore writes.
  - 0x4000 mtimecmp.
  - 0xBFF8 mtime.
  - For 4B accesses, offset bit 2 selects the high word: 0x4004 and 0xBFFC are the high halves.
- 4B write to one half of mtime/mtimecmp leaves the other half unchanged.
- FSM has two states, IDLE and RESP.
  - IDLE: req_ready_and_o = 1, resp_v_o = 0. On handshake, perform the write/read and latch resp_data_o/resp_err_o in the same edge, then go to RESP.
  - RESP: req_ready_and_o = 0, resp_v_o = 1, and response fields stay stable until resp_yumi_i, then return to IDLE.
  - Latency: response valid the cycle after acceptance. Max throughput is one request per 2 cycles. Only one request is outstanding.
- Read data is a snapshot at acceptance; later mtime ticks do not alter a held response.
- mtime increments on each rtc_tick_i with 64-bit wrap (all-ones -> 0).
- A write to mtime in the same cycle as rtc_tick_i: the write wins and the tick is dropped.
- timer_irq_o is registered: it reflects (mtime >= mtimecmp, unsigned) as sampled at the previous edge, so the interrupt lags one cycle after a tick or write.
- software_irq_o = msip register output (registered).
- Reset (reset_n_i = 0, async):
  - mtime = 0, mtimecmp = all-ones, msip = 0, FSM = IDLE.
  - resp_v_o = 0, resp_data_o = 0, resp_err_o = 0, timer_irq_o = 0, software_irq_o = 0.
  - req_ready_and_o = 0 while reset is asserted.
- Reset mid-RESP discards the pending response.
- Requests outside the decoded offsets always complete with a response; the core never hangs on them.

Optional Feature:
- Macro BP_CLINT_ERR_RESP_EN.
- Defined: an unmapped offset sets resp_err_o = 1 with resp_data_o = 0, and writes are dropped.
- Undefined: resp_err_o tied 0; unmapped reads return 0 and unmapped writes are silently dropped.

Test Plan:
- Reset then 8B read of 0x4000 -> resp_v_o the next cycle; data 0xFFFF_FFFF_FFFF_FFFF; timer_irq_o = 0.
- Write mtimecmp = 5, then 5 rtc_tick_i pulses -> timer_irq_o rises exactly 1 cycle after the 5th tick; 8B read of 0xBFF8 returns 5.
- Write mtime = 0xFFFF_FFFF_FFFF_FFFF, one tick -> mtime reads 0; simultaneous mtime write of 0x10 with a tick -> reads 0x10.
- 4B write 0x1234 to 0x4004 after mtimecmp = 0 -> 8B read of 0x4000 returns 0x0000_1234_0000_0000.
- Write msip = 0xFFFF_FFFF -> software_irq_o = 1 and readback = 1. Hold resp_yumi_i low 10 cycles -> response stable and req_ready_and_o = 0 throughout.
- Read offset 0x2000 -> data 0 with resp_err_o = 1 (macro defined) / 0 (undefined). Assert reset during RESP -> resp_v_o drops immediately, then returns to IDLE.
